// File: rtl/mmio_bridge_if.sv
// rtl/mmio_bridge_if.sv - CPU-side request/response and slave-side bus signals of mmio_bridge
//
// master modport: the environment (CPU plus slave devices) driving requests and slave responses
//   out cpu_req, cpu_we, cpu_addr[31:0], cpu_wdata[31:0], slv_rdata[N_SLV*32-1:0], slv_ready[N_SLV-1:0]
//   in  cpu_rdata[31:0], cpu_ready, cpu_err, slv_sel[N_SLV-1:0], slv_we, slv_addr[31:0],
//       slv_wdata[31:0], err_cnt[15:0]
// slave modport: the bridge itself, with the opposite directions

interface mmio_bridge_if #(
  parameter int N_SLV = 4
);

  logic                 cpu_req;
  logic                 cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_err;

  logic [N_SLV-1:0]     slv_sel;
  logic                 slv_we;
  logic [31:0]          slv_addr;
  logic [31:0]          slv_wdata;
  logic [N_SLV*32-1:0]  slv_rdata;
  logic [N_SLV-1:0]     slv_ready;

  logic [15:0]          err_cnt;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
    input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, err_cnt
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
    output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, err_cnt
  );

endinterface

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - single-master MMIO bridge: address decode, wait/timeout handling, error completion
//
// Ports:
//   clk   in  single clock, rising edge
//   rstn  in  synchronous active-low reset
//   bus   mmio_bridge_if.slave
//         cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_ready/cpu_err out (one-cycle completion)
//         slv_sel/slv_we/slv_addr/slv_wdata out (registered), slv_rdata/slv_ready in (per channel)
//         err_cnt out, saturating count of error completions
//
// SLV_BASE / SLV_MASK slot i occupies bits [32i+31:32i].

module mmio_bridge #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F020, 32'hFFFF_F000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {4{32'hFFFF_FFE0}},
  parameter int                  TIMEOUT  = 16,
  parameter logic [31:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rstn,
  mmio_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [N_SLV-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       wait_q, wait_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             hit;
  logic [N_SLV-1:0] hit_sel;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic [7:0]       wait_nxt;
  logic [15:0]      err_cnt_inc;

  // Address decode; scanning upward and stopping at the first hit gives the
  // lowest index priority when windows overlap.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit && ((bus.cpu_addr & SLV_MASK[i*32 +: 32]) ==
                   (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32]))) begin
        hit        = 1'b1;
        hit_sel[i] = 1'b1;
      end
    end
  end

  // Only the selected channel's ready/data are looked at; sel_q is one-hot or zero.
  always_comb begin
    sel_ready = |(bus.slv_ready & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) begin
        sel_rdata = bus.slv_rdata[i*32 +: 32];
      end
    end
  end

  assign wait_nxt    = wait_q + 8'd1;
  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (hit) begin
            state_d = ACCESS;
            sel_d   = hit_sel;
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            wait_d  = '0;
          end else begin
            state_d   = ERR;
            rdata_d   = ERR_DATA;
            err_cnt_d = err_cnt_inc;
          end
        end
      end

      ACCESS: begin
        wait_d = wait_nxt;
        // Ready is tested first so that it wins over a coincident timeout.
        if (sel_ready) begin
          state_d = DONE;
          rdata_d = we_q ? 32'd0 : sel_rdata;
          sel_d   = '0;
          we_d    = 1'b0;
        end else if (wait_nxt == TIMEOUT_CNT) begin
          state_d   = ERR;
          rdata_d   = ERR_DATA;
          sel_d     = '0;
          we_d      = 1'b0;
          err_cnt_d = err_cnt_inc;
        end
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // The completion pulse is the one-cycle DONE/ERR state itself.
  assign bus.cpu_ready = (state_q == DONE) || (state_q == ERR);
  assign bus.cpu_err   = (state_q == ERR);
  assign bus.cpu_rdata = rdata_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - scoreboard testbench for mmio_bridge

module tb_mmio_bridge;

  localparam int N = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_bridge_if #(.N_SLV(N)) bus ();

  mmio_bridge #(.N_SLV(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] ecnt;
    int          at;
  } resp_t;

  typedef struct {
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sreq_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [3:0]  noise;
    bit          hold;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  resp_t rq[$];
  sreq_t sq[$];
  vec_t  vt[$];

  int          dly_all = 0;
  logic [3:0]  noise   = 4'b0000;
  int          acnt[N] = '{default: 0};
  logic [15:0] model_ecnt = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Slave devices: channel i raises ready in its (dly_all+1)-th selected cycle;
  // unselected channels drive the noise pattern, which the bridge must ignore.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.slv_sel[i]) begin
        bus.slv_ready[i] = (acnt[i] == dly_all);
        acnt[i]++;
      end else begin
        acnt[i] = 0;
        bus.slv_ready[i] = noise[i];
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rstn && bus.cpu_ready) begin
      if (rq.size() == 0) begin
        check("unexpected_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      end else begin
        e = rq.pop_front();
        check("cpu_rdata", bus.cpu_rdata, e.rdata);
        check("cpu_err",   32'(bus.cpu_err), 32'(e.err));
        check("err_cnt",   32'(bus.err_cnt), 32'(e.ecnt));
        check("latency",   32'(cyc), 32'(e.at));
      end
    end
  end

  // Slave-side monitor: selection contents on the first selected cycle,
  // stability while selected, no write strobe while deselected.
  logic [3:0]  prev_sel = '0;
  logic        prev_we  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_wdata = '0;

  always @(negedge clk) begin
    sreq_t s;
    if (rstn) begin
      if (bus.slv_sel != 4'b0000) begin
        if (prev_sel == 4'b0000) begin
          if (sq.size() == 0) begin
            check("unexpected_slv_sel", 32'(bus.slv_sel), 32'd0);
          end else begin
            s = sq.pop_front();
            check("slv_sel",   32'(bus.slv_sel), 32'(s.sel));
            check("slv_we",    32'(bus.slv_we),  32'(s.we));
            check("slv_addr",  bus.slv_addr,  s.addr);
            check("slv_wdata", bus.slv_wdata, s.wdata);
          end
        end else begin
          check("sel_stable",   32'(bus.slv_sel), 32'(prev_sel));
          check("we_stable",    32'(bus.slv_we),  32'(prev_we));
          check("addr_stable",  bus.slv_addr,  prev_addr);
          check("wdata_stable", bus.slv_wdata, prev_wdata);
        end
      end else if (bus.slv_we !== 1'b0) begin
        check("slv_we_idle", 32'(bus.slv_we), 32'd0);
      end
    end
    prev_sel   = bus.slv_sel;
    prev_we    = bus.slv_we;
    prev_addr  = bus.slv_addr;
    prev_wdata = bus.slv_wdata;
  end

  // Issue one vector from a negedge where the bridge will be IDLE next cycle.
  task automatic run_vec(input vec_t v);
    resp_t e;
    sreq_t s;
    bit    seen;
    dly_all       = v.dly;
    noise         = v.noise;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    if (v.err) model_ecnt = (model_ecnt == 16'hFFFF) ? 16'hFFFF : model_ecnt + 16'd1;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.ecnt  = model_ecnt;
    e.at    = cyc + v.lat;
    rq.push_back(e);
    if (v.sel != 4'b0000) begin
      s.sel = v.sel; s.we = v.we; s.addr = v.addr; s.wdata = v.wdata;
      sq.push_back(s);
    end
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) seen = 1'b1;
    end
    if (!seen) check("cpu_ready_wait", 32'd0, 32'd1);
    if (!v.hold) bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_slv_sel"},   32'(bus.slv_sel), 32'd0);
    check({tag, "_slv_we"},    32'(bus.slv_we),  32'd0);
    check({tag, "_slv_addr"},  bus.slv_addr,  32'd0);
    check({tag, "_slv_wdata"}, bus.slv_wdata, 32'd0);
    check({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
    check({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_cpu_err"},   32'(bus.cpu_err),   32'd0);
    check({tag, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_F00D};

    //               we    addr          wdata         dly noise    hold  sel      err   rdata         lat
    vt.push_back('{1'b0, 32'hFFFF_F020, 32'h0,        0,  4'b0000, 1'b0, 4'b0010, 1'b0, 32'h1234_5678, 2});
    vt.push_back('{1'b1, 32'hFFFF_F000, 32'hA5A5_0001, 3, 4'b0000, 1'b0, 4'b0001, 1'b0, 32'h0,        5});
    vt.push_back('{1'b0, 32'h0000_1000, 32'h0,        0,  4'b0000, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});
    vt.push_back('{1'b0, 32'hFFFF_F064, 32'h0,       -1,  4'b1011, 1'b0, 4'b0100, 1'b1, 32'hDEAD_BEEF, 17});
    vt.push_back('{1'b0, 32'hFFFF_F07C, 32'h0,       15,  4'b0000, 1'b0, 4'b0100, 1'b0, 32'h2222_2222, 17});
    vt.push_back('{1'b0, 32'hFFFF_F03F, 32'h0,        1,  4'b0001, 1'b0, 4'b0010, 1'b0, 32'h1234_5678, 3});
    vt.push_back('{1'b0, 32'hFFFF_F040, 32'h0,        0,  4'b0000, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});
    vt.push_back('{1'b0, 32'hFFFF_F01F, 32'h0,        0,  4'b0000, 1'b1, 4'b0001, 1'b0, 32'h0BAD_F00D, 2});
    vt.push_back('{1'b1, 32'hFFFF_F030, 32'h0000_0001, 0, 4'b0000, 1'b1, 4'b0010, 1'b0, 32'h0,        2});
    vt.push_back('{1'b0, 32'hFFFF_E000, 32'h0,        0,  4'b0000, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the second ACCESS cycle of a never-ready access.
    begin
      sreq_t s;
      dly_all = -1;
      noise   = 4'b0000;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'hFFFF_F060;
      bus.cpu_wdata = 32'h0;
      s.sel = 4'b0100; s.we = 1'b0; s.addr = 32'hFFFF_F060; s.wdata = 32'h0;
      sq.push_back(s);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      model_ecnt = 16'd0;
      check_all_zero("midreset");
      repeat (4) @(negedge clk);
      run_vec('{1'b0, 32'hFFFF_F020, 32'h0, 0, 4'b0000, 1'b0, 4'b0010, 1'b0, 32'h1234_5678, 2});
    end

    // Saturation: preload the counter near its ceiling, then miss three times.
    force dut.err_cnt_q = 16'hFFFD;
    @(negedge clk);
    @(negedge clk);
    release dut.err_cnt_q;
    model_ecnt = 16'hFFFD;
    @(negedge clk);
    run_vec('{1'b0, 32'h0000_0000, 32'h0, 0, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});
    run_vec('{1'b1, 32'h8000_0000, 32'h5, 0, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});
    run_vec('{1'b0, 32'hFFFF_FFFC, 32'h0, 0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1});
    repeat (2) @(negedge clk);
    check("err_cnt_saturated", 32'(bus.err_cnt), 32'h0000_FFFF);
    check("resp_queue_empty",  32'(rq.size()), 32'd0);
    check("sel_queue_empty",   32'(sq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
